// File: rtl/jedro_1_ifu_pkg.sv
// jedro_1_ifu_pkg
// Shared types and constants for the jedro_1 instruction fetch unit.
//   NOP_INSTR      : word presented while nothing valid is buffered (addi x0,x0,0)
//   ifu_entry_t    : one prefetch buffer entry {addr, instr}
//   ifu_ptr_w()    : FIFO pointer width for a given depth
//   ifu_cnt_w()    : FIFO occupancy width for a given depth (must hold DEPTH itself)
package jedro_1_ifu_pkg;

    localparam int IFU_ADDR_W     = 32;
    localparam int IFU_DATA_W     = 32;
    localparam int IFU_FIFO_DEPTH = 4;

    localparam logic [IFU_DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [IFU_ADDR_W-1:0] addr;
        logic [IFU_DATA_W-1:0] instr;
    } ifu_entry_t;

    function automatic int ifu_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int ifu_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int IFU_CNT_W = ifu_cnt_w(IFU_FIFO_DEPTH);

endpackage

// File: rtl/jedro_1_ifu_fifo.sv
// jedro_1_ifu_fifo
// Synchronous FIFO of ifu_entry_t used as the prefetch buffer.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   flush_i      : drop all entries this cycle (wins over push and pop)
//   push_i       : write entry_i
//   entry_i      : entry to write
//   pop_i        : remove the head entry
//   entry_o      : head entry (meaningful only when not empty)
//   count_o      : number of valid entries
//   empty_o      : no entries
//   full_o       : DEPTH entries
// DEPTH must be a power of two so the pointers wrap naturally.
module jedro_1_ifu_fifo
    import jedro_1_ifu_pkg::*;
#(
    parameter int DEPTH = IFU_FIFO_DEPTH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          push_i,
    input  ifu_entry_t                    entry_i,
    input  logic                          pop_i,
    output ifu_entry_t                    entry_o,
    output logic [ifu_cnt_w(DEPTH)-1:0]   count_o,
    output logic                          empty_o,
    output logic                          full_o
);

    localparam int PTR_W = ifu_ptr_w(DEPTH);
    localparam int CNT_W = ifu_cnt_w(DEPTH);

    ifu_entry_t         mem_q [DEPTH];
    ifu_entry_t         mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok;
    logic               pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign entry_o = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok   = pop_i && !empty_o;
        // A full FIFO may still accept a push when the head leaves in the same cycle.
        push_ok  = push_i && (!full_o || pop_ok);

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = entry_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push_ok && pop_ok) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/jedro_1_ifu_prefetch.sv
// jedro_1_ifu_prefetch
// Instruction fetch stage: issues sequential ROM reads, buffers returned words
// with their addresses and hands them to the decoder over valid/ready.
// A redirect from execute flushes the buffer and any in-flight fetch.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   jmp_addr_i     : redirect target (aligned down to a word)
//   jmp_valid_i    : redirect request pulse
//   mem_en_o       : ROM read enable
//   mem_addr_o     : ROM byte address
//   mem_rdata_i    : ROM data, one cycle after mem_en_o
//   instr_o        : instruction to decoder (NOP when nothing is buffered)
//   instr_addr_o   : address of instr_o (0 when nothing is buffered)
//   instr_valid_o  : instr_o is valid
//   ready_i        : decoder accepts instr_o this cycle
//   misaligned_o   : one-cycle flag after a redirect with a non-word-aligned target
// Build option JEDRO_1_IFU_MISALIGN_EN enables misaligned_o; otherwise it is tied 0.
module jedro_1_ifu_prefetch
    import jedro_1_ifu_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] jmp_addr_i,
    input  logic                  jmp_valid_i,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    output logic                  instr_valid_o,
    input  logic                  ready_i,
    output logic                  misaligned_o
);

    localparam int CNT_W = ifu_cnt_w(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] inflight_addr_q, inflight_addr_d;

    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [CNT_W:0]        occupancy;
    ifu_entry_t            push_entry;
    ifu_entry_t            head_entry;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;

    jedro_1_ifu_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (jmp_valid_i),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .entry_o (head_entry),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_comb begin
        // The in-flight fetch reserves a slot so its response can never overflow.
        occupancy        = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
        issue            = !rst_i && !jmp_valid_i && !fifo_full
                           && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
        // A response arriving in a redirect cycle belongs to the old stream.
        push             = inflight_q && !jmp_valid_i;
        pop              = !fifo_empty && ready_i && !jmp_valid_i;
        push_entry.addr  = inflight_addr_q;
        push_entry.instr = mem_rdata_i;

        pc_d             = pc_q;
        inflight_d       = issue;
        inflight_addr_d  = inflight_addr_q;

        if (jmp_valid_i) begin
            pc_d = jmp_addr_i & ~ADDR_WIDTH'(3);
        end else if (issue) begin
            pc_d            = pc_q + ADDR_WIDTH'(4);
            inflight_addr_d = pc_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q            <= BOOT_ADDR;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
        end else begin
            pc_q            <= pc_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
        end
    end

    assign mem_en_o      = issue;
    assign mem_addr_o    = pc_q;
    assign instr_valid_o = !fifo_empty;
    assign instr_o       = fifo_empty ? DATA_WIDTH'(NOP_INSTR) : head_entry.instr;
    assign instr_addr_o  = fifo_empty ? '0 : head_entry.addr;

`ifdef JEDRO_1_IFU_MISALIGN_EN
    logic misaligned_q, misaligned_d;

    always_comb begin
        misaligned_d = jmp_valid_i && (jmp_addr_i[1:0] != 2'b00);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end

    assign misaligned_o = misaligned_q;
`else
    assign misaligned_o = 1'b0;
`endif

endmodule

// File: tb/tb_jedro_1_ifu_prefetch.sv
// tb_jedro_1_ifu_prefetch
// Directed scenarios followed by randomized ready/redirect traffic. The reference
// model tracks the expected instruction stream as plain arithmetic: the next
// address the decoder should see, the next address to be fetched, and how many
// fetched-but-not-accepted words exist since the last flush.
module tb_jedro_1_ifu_prefetch;
    import jedro_1_ifu_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BOOT  = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] jmp_addr_i = '0;
    logic        jmp_valid_i = 1'b0;
    logic        mem_en_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rdata_i = '0;
    logic [31:0] instr_o;
    logic [31:0] instr_addr_o;
    logic        instr_valid_o;
    logic        ready_i = 1'b0;
    logic        misaligned_o;

    jedro_1_ifu_prefetch #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .FIFO_DEPTH    (DEPTH),
        .BOOT_ADDR     (BOOT)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .jmp_addr_i    (jmp_addr_i),
        .jmp_valid_i   (jmp_valid_i),
        .mem_en_o      (mem_en_o),
        .mem_addr_o    (mem_addr_o),
        .mem_rdata_i   (mem_rdata_i),
        .instr_o       (instr_o),
        .instr_addr_o  (instr_addr_o),
        .instr_valid_o (instr_valid_o),
        .ready_i       (ready_i),
        .misaligned_o  (misaligned_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_10b7;
            32'h4:   return 32'h0000_2137;
            32'h8:   return 32'h0000_31b7;
            default: return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
        endcase
    endfunction

    // ROM read port: data one cycle after the enable; garbage when not enabled.
    always @(posedge clk_i) begin
        if (mem_en_o) mem_rdata_i <= rom(mem_addr_o);
        else          mem_rdata_i <= 32'hDEAD_BEEF;
    end

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] exp_next;
    logic [31:0] exp_issue;
    int          outstanding;
    logic        prev_issue;
    logic        exp_mis;

    // Sampled outputs of the most recent step
    logic        s_valid, s_en, s_mis;
    logic [31:0] s_addr, s_instr, s_maddr;
    int          n_issue;
    logic [31:0] acc_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_next    = BOOT;
        exp_issue   = BOOT;
        outstanding = 0;
        prev_issue  = 1'b0;
        exp_mis     = 1'b0;
    endtask

    // Hold reset for n edges, checking outputs after each; release at a negedge.
    task automatic do_reset(input int n);
        rst_i = 1'b1; ready_i = 1'b0; jmp_valid_i = 1'b0; jmp_addr_i = '0;
        repeat (n) begin
            @(posedge clk_i); #1;
            chk("rst_mem_en", 32'(mem_en_o), 32'd0);
            chk("rst_valid",  32'(instr_valid_o), 32'd0);
            chk("rst_instr",  instr_o, NOP_INSTR);
            chk("rst_addr",   instr_addr_o, 32'd0);
            chk("rst_mis",    32'(misaligned_o), 32'd0);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive, sample, check against the model, advance the model.
    task automatic step(input logic rdy, input logic jmp, input logic [31:0] tgt);
        int   fifo_cnt;
        logic exp_en;
        logic acc;
        ready_i = rdy; jmp_valid_i = jmp; jmp_addr_i = tgt;
        #1;
        s_valid = instr_valid_o; s_addr = instr_addr_o; s_instr = instr_o;
        s_en = mem_en_o; s_maddr = mem_addr_o; s_mis = misaligned_o;

        fifo_cnt = outstanding - (prev_issue ? 1 : 0);
        exp_en   = !jmp && (outstanding < DEPTH);
        chk("valid",  32'(s_valid), 32'(fifo_cnt > 0));
        chk("mis",    32'(s_mis), 32'(exp_mis));
        chk("mem_en", 32'(s_en), 32'(exp_en));
        if (s_en) chk("mem_addr", s_maddr, exp_issue);
        if (s_valid) begin
            chk("instr_addr", s_addr, exp_next);
            chk("instr", s_instr, rom(exp_next));
        end
        acc = s_valid && rdy && !jmp;
        if (acc) acc_q.push_back(s_addr);
        if (s_en) n_issue++;

        @(posedge clk_i);
        if (jmp) begin
            exp_next    = tgt & ~32'h3;
            exp_issue   = exp_next;
            outstanding = 0;
            prev_issue  = 1'b0;
        end else begin
            if (exp_en) begin
                exp_issue = exp_issue + 32'd4;
                outstanding++;
            end
            if (acc) begin
                exp_next = exp_next + 32'd4;
                outstanding--;
            end
            prev_issue = exp_en;
        end
`ifdef JEDRO_1_IFU_MISALIGN_EN
        exp_mis = jmp && (tgt[1:0] != 2'b00);
`else
        exp_mis = 1'b0;
`endif
        @(negedge clk_i);
    endtask

    task automatic wait_valid(input string tag, input logic rdy, input int n);
        logic got = 1'b0;
        for (int i = 0; i < n && !got; i++) begin
            step(rdy, 1'b0, 32'h0);
            got = s_valid;
        end
        chk(tag, 32'(got), 32'd1);
    endtask

    function automatic logic [31:0] acc_at(input int i);
        return (i < acc_q.size()) ? acc_q[i] : 32'hFFFF_FFFF;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rv[5];
        logic [31:0] ra[5];
        logic [31:0] ri[5];
        logic [31:0] lui[3];
        logic        got;
        lui[0] = 32'h0000_10b7; lui[1] = 32'h0000_2137; lui[2] = 32'h0000_31b7;
        n_issue = 0;
        model_reset();

        // Reset values
        @(negedge clk_i);
        do_reset(3);

        // Sequential fetch, first valid two cycles after release
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 32'h0);
            rv[k] = s_valid; ra[k] = s_addr; ri[k] = s_instr;
        end
        chk("seq_lat0", 32'(rv[0]), 32'd0);
        chk("seq_lat1", 32'(rv[1]), 32'd0);
        for (int k = 2; k < 5; k++) begin
            chk("seq_valid", 32'(rv[k]), 32'd1);
            chk("seq_addr",  ra[k], 32'((k - 2) * 4));
            chk("seq_instr", ri[k], lui[k-2]);
        end

        // Backpressure: exactly DEPTH issues, head holds, then in-order drain
        do_reset(1);
        n_issue = 0;
        repeat (10) step(1'b0, 1'b0, 32'h0);
        chk("bp_issues", 32'(n_issue), 32'(DEPTH));
        chk("bp_hold_valid", 32'(s_valid), 32'd1);
        chk("bp_hold_addr", s_addr, 32'h0);
        acc_q.delete();
        repeat (6) step(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) chk("bp_drain", acc_at(i), 32'(i * 4));

        // Redirect with a fetch in flight and two entries buffered
        do_reset(1);
        repeat (3) step(1'b0, 1'b0, 32'h0);
        chk("rd_pre_valid", 32'(s_valid), 32'd1);
        step(1'b0, 1'b1, 32'h40);
        chk("rd_no_issue", 32'(s_en), 32'd0);
        step(1'b1, 1'b0, 32'h0);
        chk("rd_valid_drop", 32'(s_valid), 32'd0);
        wait_valid("rd_wait", 1'b1, 6);
        chk("rd_target", s_addr, 32'h40);

        // Redirect coinciding with a pop, then a second redirect
        step(1'b1, 1'b1, 32'h60);
        step(1'b1, 1'b1, 32'h80);
        acc_q.delete();
        wait_valid("rr_wait", 1'b1, 6);
        chk("rr_target", s_addr, 32'h80);
        repeat (3) step(1'b1, 1'b0, 32'h0);
        chk("rr_seq", acc_at(1), 32'h84);

        // Reset in the middle of a run
        do_reset(1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1'b1, 1'b0, 32'h0);
            got = s_en && (s_maddr == 32'h20);
        end
        chk("mr_reach", 32'(got), 32'd1);
        do_reset(2);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 32'h0);
            rv[k] = s_valid; ra[k] = s_addr;
        end
        chk("mr_lat", 32'(rv[1]), 32'd0);
        chk("mr_valid", 32'(rv[2]), 32'd1);
        chk("mr_addr", ra[2], BOOT);

        // Misaligned redirect
        step(1'b1, 1'b1, 32'h42);
        step(1'b1, 1'b0, 32'h0);
`ifdef JEDRO_1_IFU_MISALIGN_EN
        chk("mis_pulse", 32'(s_mis), 32'd1);
`else
        chk("mis_pulse", 32'(s_mis), 32'd0);
`endif
        step(1'b1, 1'b0, 32'h0);
        chk("mis_clear", 32'(s_mis), 32'd0);
        wait_valid("mis_wait", 1'b1, 6);
        chk("mis_target", s_addr, 32'h40);

        // PC wrap
        step(1'b1, 1'b1, 32'hFFFF_FFF8);
        acc_q.delete();
        repeat (8) step(1'b1, 1'b0, 32'h0);
        chk("wrap0", acc_at(0), 32'hFFFF_FFF8);
        chk("wrap1", acc_at(1), 32'hFFFF_FFFC);
        chk("wrap2", acc_at(2), 32'h0000_0000);
        chk("wrap3", acc_at(3), 32'h0000_0004);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic        rdy;
            logic        jmp;
            logic [31:0] tgt;
            rdy = ($urandom_range(0, 3) != 0);
            jmp = ($urandom_range(0, 15) == 0);
            tgt = $urandom;
            step(rdy, jmp, tgt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/jedro_1_ifu_prefetch.md
Name: jedro_1_ifu_prefetch

Overview:
- Instruction fetch stage of jedro_1.
- Sits directly upstream of the decoder and issues sequential reads to the instruction ROM read port.
- Buffers returned words with their addresses in a small FIFO and presents them to the decoder with a valid/ready handshake.
- On a jump or branch request from execute it flushes the FIFO and in-flight fetches, then redirects the PC.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, byte address width.
- FIFO_DEPTH, 4, prefetch entries; power of two, at least 2.
- BOOT_ADDR, 32'h0000_0000, PC value after reset.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- jmp_addr_i  in  ADDR_WIDTH  redirect target.
- jmp_valid_i  in  1  redirect request, single-cycle pulse.
- mem_en_o  out  1  ROM read enable.
- mem_addr_o  out  ADDR_WIDTH  ROM byte address.
- mem_rdata_i  in  DATA_WIDTH  ROM data, valid one cycle after mem_en_o.
- instr_o  out  DATA_WIDTH  instruction to decoder.
- instr_addr_o  out  ADDR_WIDTH  address of instr_o.
- instr_valid_o  out  1  instr_o is valid.
- ready_i  in  1  decoder accepts instr_o this cycle.
- misaligned_o  out  1  misaligned redirect flag; tied 0 unless the macro is defined.

Behaviour:
- Reset (synchronous, active-high) sets:
  - pc to BOOT_ADDR
  - FIFO empty
  - in-flight flag 0
  - mem_en_o 0
  - instr_valid_o 0
  - instr_o 32'h0000_0013 (NOP)
  - instr_addr_o 0
  - misaligned_o 0
- Fetch issue: mem_en_o=1 and mem_addr_o=pc when (count + inflight) < FIFO_DEPTH and no redirect is active this cycle; pc += 4 on issue.
- Response: the cycle after an issue, mem_rdata_i and its address are pushed into the FIFO unless that fetch was killed.
- Latency: the first instruction is valid 2 cycles after rst_i deasserts (issue, capture, present). Steady-state throughput is 1 instruction per cycle.
- Output: instr_valid_o = FIFO not empty. instr_o and instr_addr_o are the FIFO head and hold stable while valid and not ready.
- Handshake: pop occurs on instr_valid_o && ready_i.
- Full FIFO: no issue. The space reserved by the in-flight fetch guarantees a response never overflows.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Empty FIFO with a response arriving: no bypass. Data is visible the next cycle.
- Redirect (jmp_valid_i=1), in the same cycle:
  - FIFO is cleared.
  - Any pending in-flight response is marked killed and dropped on arrival.
  - pc <= {jmp_addr_i[ADDR_WIDTH-1:2], 2'b00}.
  - No issue occurs.
  - instr_valid_o drops the next cycle.
  - The first fetch from the target is issued the cycle after the redirect.
- A redirect coinciding with a pop: the pop is ignored; the flush wins.
- Back-to-back redirects: the last one wins; each kills the previous target's fetch.
- pc wraps modulo 2^ADDR_WIDTH with no flag.
- Reset asserted mid-operation: pending fetch is discarded, all state returns to reset values, and no response is pushed afterwards.

Optional Feature:
- Macro: JEDRO_1_IFU_MISALIGN_EN.
- Defined: a redirect with jmp_addr_i[1:0] != 0 sets misaligned_o=1 for exactly one cycle, the cycle after the redirect. pc is still aligned down.
- Undefined: misaligned_o is constant 0 and no checking logic is built.

Decomposition:
- Package jedro_1_ifu_pkg holds:
  - NOP_INSTR = 32'h0000_0013
  - typedef ifu_entry_t struct {addr, instr}
  - localparams for count width.
- Sub-module jedro_1_ifu_fifo: synchronous FIFO of ifu_entry_t with push, pop, flush, count, empty and full. Depth parameterised and pointers wrap by power of two.

Test Plan:
- Sequential fetch: ROM words at 0x0, 0x4, 0x8 are 0x00001_0b7, 0x00002_137, 0x00003_1b7 (lui x1..x3); ready_i=1 -> instr_addr_o 0,4,8 on consecutive cycles starting 2 cycles after reset, with matching instr_o.
- Backpressure: ready_i=0 for 10 cycles -> exactly FIFO_DEPTH=4 issues; instr_o holds at addr 0; no overflow. On release, addrs 0..0xC drain in order, then 0x10 follows.
- Redirect: jmp_valid_i with target 0x40 while a fetch is in flight and the FIFO is half full -> next cycle instr_valid_o=0; stale data never appears; next valid instr_addr_o=0x40.
- Redirect plus pop in the same cycle, then a second redirect to 0x80 the next cycle -> only 0x80 is presented.
- Reset mid-run at pc=0x20 -> the first instruction after reset is from BOOT_ADDR, with all outputs at reset values during reset.
- With JEDRO_1_IFU_MISALIGN_EN, jump to 0x42 -> misaligned_o high for one cycle; fetch resumes at 0x40. Without the macro, misaligned_o stays 0.
